packet_fifo: RTL and testbench
==============================

// Module: packet_fifo
// PURPOSE
//  Parametrised packet-aware FIFO; successor to the flat byte FIFO used for packet holding.
//  Buffers DATA_W-bit words between the USB receive path and the AES datapath.
//  Writes are staged until w_commit publishes a whole packet; w_discard drops it (bad CRC/PID).
//  Uses all DEPTH entries (extra pointer MSB); adds count, space and almost-full/empty flags.
// PARAMETERS
//  DATA_W     8   word width in bits
//  DEPTH      64  number of entries; power of 2, >= 4
//  ADDR_W     6   log2(DEPTH); pointers are ADDR_W+1 bits
//  AF_THRESH  56  almost_full asserts when used space >= AF_THRESH
//  AE_THRESH  8   almost_empty asserts when committed count <= AE_THRESH
// PORTS
//  clk           in   1         clock, rising edge
//  n_rst         in   1         asynchronous reset, active low
//  w_enable      in   1         write request
//  w_data        in   DATA_W    write word
//  w_commit      in   1         publish all staged words, including any written this cycle
//  w_discard     in   1         drop all staged words; rewind write pointer to commit pointer
//  r_enable      in   1         read/pop request
//  r_data        out  DATA_W    head word; first-word fall-through, valid when !empty
//  empty         out  1         no committed words
//  full          out  1         staged + committed words == DEPTH
//  almost_full   out  1         see AF_THRESH
//  almost_empty  out  1         see AE_THRESH
//  count         out  ADDR_W+1  committed words readable, 0..DEPTH
//  space         out  ADDR_W+1  free entries, DEPTH - (staged + committed)
//  overflow      out  1         `FIFO_ERR_EN only: sticky, write attempted while full
//  underflow     out  1         `FIFO_ERR_EN only: sticky, read attempted while empty
//  err_clr       in   1         `FIFO_ERR_EN only: synchronous clear of overflow/underflow
// BEHAVIOUR
//  - Pointers: wr_ptr (staging), cm_ptr (committed), rd_ptr; all ADDR_W+1 bits, wrap mod 2*DEPTH.
//  - Reset: all pointers 0, memory contents 0; empty=1, almost_empty=1, full=0, almost_full=0,
//    count=0, space=DEPTH, r_data=0, overflow=underflow=0.
//  - Write: w_enable && !full -> mem[wr_ptr] <= w_data, wr_ptr++ at the edge. Write while full is dropped.
//  - Commit: w_commit -> cm_ptr <= wr_ptr_next (includes same-cycle write); empty falls the next cycle.
//  - Discard: w_discard -> wr_ptr <= cm_ptr; a same-cycle write is dropped; discard beats commit.
//  - Read: r_enable && !empty -> rd_ptr++; r_data = mem[rd_ptr] combinational, 0 when empty.
//    Read while empty is ignored; pointers are unchanged.
//  - Flags are combinational from registered pointers:
//    empty = (cm_ptr == rd_ptr); full = (wr_ptr - rd_ptr == DEPTH).
//    count = cm_ptr - rd_ptr; space = DEPTH - (wr_ptr - rd_ptr).
//  - Simultaneous read+write when full: read proceeds, write dropped (full evaluated pre-edge).
//  - Simultaneous read+write when not full and not empty: both proceed; space is unchanged if no commit.
//  - Staged words never visible to reader; reader may drain committed data while a packet stages.
//  - Reset mid-packet discards staged and committed data alike.
// CONFIGURATION
//  FIFO_ERR_EN defined:
//    overflow sets on w_enable && full; underflow sets on r_enable && empty.
//    Both hold until err_clr or reset; a set event in the same cycle as err_clr wins.
//  FIFO_ERR_EN undefined:
//    overflow, underflow and err_clr ports are absent; dropped accesses are silent.
// TESTING
//  - Reset, then 4 writes 0x11..0x14 with no commit -> empty=1, count=0, space=60; commit -> count=4 next cycle.
//  - Write 3 words + w_commit on the 3rd -> count=3; pop 3 -> r_data 1st/2nd/3rd, then empty=1.
//  - Commit 2 words, stage 5, w_discard -> count=2, space=62; the next write lands after word 2.
//  - Fill 64 with commit -> full=1, space=0; write 0xAA + read same cycle -> read ok, 0xAA dropped, count=63.
//  - Cross wrap: 3 rounds of 40 write/commit/drain -> data order intact; almost_full at 56, almost_empty at 8.
//  - FIFO_ERR_EN: read when empty -> underflow=1 sticky; err_clr -> 0; write when full -> overflow=1.

Source files
------------

// File: rtl/packet_fifo.sv
`timescale 1ns/1ps
// packet_fifo: packet-aware FIFO; writes stage until w_commit publishes them, w_discard drops them.
// Optional sticky overflow/underflow flags with err_clr when FIFO_ERR_EN is defined.
module packet_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = 6,
    parameter int AF_THRESH = 56,
    parameter int AE_THRESH = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              w_enable,
    input  logic [DATA_W-1:0] w_data,
    input  logic              w_commit,
    input  logic              w_discard,
    input  logic              r_enable,
    output logic [DATA_W-1:0] r_data,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W:0]   space
`ifdef FIFO_ERR_EN
    ,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
`endif
);
    localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] L_AF    = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] L_AE    = (ADDR_W+1)'(AE_THRESH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]   r_wr_ptr, r_cm_ptr, r_rd_ptr;
    logic [ADDR_W:0]   w_used, w_wr_next;
    logic              w_do_wr, w_do_rd;

    always_comb begin
        w_used       = r_wr_ptr - r_rd_ptr;
        full         = (w_used == L_DEPTH);
        empty        = (r_cm_ptr == r_rd_ptr);
        count        = r_cm_ptr - r_rd_ptr;
        space        = L_DEPTH - w_used;
        almost_full  = (w_used >= L_AF);
        almost_empty = (count <= L_AE);
        w_do_wr      = w_enable && !full && !w_discard;
        w_do_rd      = r_enable && !empty;
        w_wr_next    = r_wr_ptr + {{ADDR_W{1'b0}}, w_do_wr};
        r_data       = empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_do_wr) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= w_data;
        end
    end

    // Discard rewinds staging to the commit point and overrides any same-cycle commit.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wr_ptr <= '0;
            r_cm_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_discard) r_wr_ptr <= r_cm_ptr;
            else begin
                r_wr_ptr <= w_wr_next;
                if (w_commit) r_cm_ptr <= w_wr_next;
            end
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

`ifdef FIFO_ERR_EN
    logic r_overflow, r_underflow;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_enable && full) r_overflow <= 1'b1;
            else if (err_clr) r_overflow <= 1'b0;
            if (r_enable && empty) r_underflow <= 1'b1;
            else if (err_clr) r_underflow <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_packet_fifo.sv
`timescale 1ns/1ps
// tb_packet_fifo: table vectors, corner sequences and random traffic against a queue model of packet_fifo.
module tb_packet_fifo;
    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       w_enable = 1'b0, w_commit = 1'b0, w_discard = 1'b0, r_enable = 1'b0, err_clr = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic [7:0] r_data;
    logic       empty, full, almost_full, almost_empty;
    logic [6:0] count, space;
`ifdef FIFO_ERR_EN
    logic       overflow, underflow;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] cq[$];
    logic [7:0] sq[$];
    logic       m_ovf = 1'b0, m_udf = 1'b0;

    always #5 clk = ~clk;

    packet_fifo dut (
        .clk(clk), .n_rst(n_rst),
        .w_enable(w_enable), .w_data(w_data), .w_commit(w_commit), .w_discard(w_discard),
        .r_enable(r_enable), .r_data(r_data),
        .empty(empty), .full(full), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .space(space)
`ifdef FIFO_ERR_EN
        , .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
`endif
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_check();
        int tot = cq.size() + sq.size();
        chk("m_count", 32'(count), 32'(cq.size()));
        chk("m_space", 32'(space), 32'(64 - tot));
        chk("m_empty", 32'(empty), 32'(cq.size() == 0));
        chk("m_full", 32'(full), 32'(tot == 64));
        chk("m_almost_full", 32'(almost_full), 32'(tot >= 56));
        chk("m_almost_empty", 32'(almost_empty), 32'(cq.size() <= 8));
        chk("m_r_data", 32'(r_data), (cq.size() == 0) ? 32'd0 : 32'(cq[0]));
`ifdef FIFO_ERR_EN
        chk("m_overflow", 32'(overflow), 32'(m_ovf));
        chk("m_underflow", 32'(underflow), 32'(m_udf));
`endif
    endfunction

    function automatic void model_edge(input logic we, input logic [7:0] wd, input logic wc,
                                       input logic wx, input logic re, input logic ec);
        bit mf = (cq.size() + sq.size()) == 64;
        bit me = cq.size() == 0;
        if (we && mf) m_ovf = 1'b1; else if (ec) m_ovf = 1'b0;
        if (re && me) m_udf = 1'b1; else if (ec) m_udf = 1'b0;
        if (re && !me) void'(cq.pop_front());
        if (wx) sq.delete();
        else begin
            if (we && !mf) sq.push_back(wd);
            if (wc) while (sq.size() > 0) cq.push_back(sq.pop_front());
        end
    endfunction

    task automatic step(input logic we, input logic [7:0] wd, input logic wc,
                        input logic wx, input logic re, input logic ec);
        w_enable = we; w_data = wd; w_commit = wc; w_discard = wx; r_enable = re; err_clr = ec;
        @(posedge clk);
        model_edge(we, wd, wc, wx, re, ec);
        #1;
        model_check();
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       wc, wx, re;
        int         cnt, spc;
        logic       emp;
        logic [7:0] rd;
    } vec_t;

    vec_t tbl[14];

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 0, 63, 1'b1, 8'h00};
        tbl[1]  = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 0, 62, 1'b1, 8'h00};
        tbl[2]  = '{1'b1, 8'h13, 1'b0, 1'b0, 1'b0, 0, 61, 1'b1, 8'h00};
        tbl[3]  = '{1'b1, 8'h14, 1'b0, 1'b0, 1'b0, 0, 60, 1'b1, 8'h00};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4, 60, 1'b0, 8'h11};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3, 61, 1'b0, 8'h12};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2, 62, 1'b0, 8'h13};
        tbl[7]  = '{1'b1, 8'h21, 1'b1, 1'b0, 1'b0, 3, 61, 1'b0, 8'h13};
        tbl[8]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 3, 61, 1'b0, 8'h13};
        tbl[9]  = '{1'b1, 8'h23, 1'b0, 1'b0, 1'b1, 2, 61, 1'b0, 8'h14};
        tbl[10] = '{1'b1, 8'h25, 1'b1, 1'b1, 1'b0, 2, 62, 1'b0, 8'h14};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1, 63, 1'b0, 8'h21};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 64, 1'b1, 8'h00};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 64, 1'b1, 8'h00};

        #3;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_almost_empty", 32'(almost_empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_almost_full", 32'(almost_full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_space", 32'(space), 32'd64);
        chk("rst_r_data", 32'(r_data), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].we, tbl[i].wd, tbl[i].wc, tbl[i].wx, tbl[i].re, 1'b0);
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_space", i), 32'(space), 32'(tbl[i].spc));
            chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].emp));
            chk($sformatf("tbl%0d_r_data", i), 32'(r_data), 32'(tbl[i].rd));
        end
`ifdef FIFO_ERR_EN
        chk("underflow_set", 32'(underflow), 32'd1);
        idle();
        chk("underflow_sticky", 32'(underflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("underflow_clr", 32'(underflow), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("underflow_set_beats_clr", 32'(underflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

        // three words, commit with the third, pop in order
        step(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("c3_count", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("c3_pop", 32'(r_data), 32'(8'hA1 + i));
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("c3_empty", 32'(empty), 32'd1);

        // commit 2, stage 5, discard; the next write follows word 2
        step(1'b1, 8'hB1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hB2, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("disc_count", 32'(count), 32'd2);
        chk("disc_space", 32'(space), 32'd62);
        step(1'b1, 8'hB3, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("disc_order", 32'(r_data), 32'(8'hB1 + i));
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // fill to 64, then write+read while full
        for (int i = 0; i < 64; i++) step(1'b1, 8'(i), i == 63, 1'b0, 1'b0, 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_space", 32'(space), 32'd0);
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("full_rw_count", 32'(count), 32'd63);
        chk("full_rw_full", 32'(full), 32'd0);
`ifdef FIFO_ERR_EN
        chk("overflow_set", 32'(overflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("overflow_clr", 32'(overflow), 32'd0);
`endif
        for (int i = 1; i < 64; i++) begin
            chk("full_drain", 32'(r_data), 32'(i));
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("full_drain_empty", 32'(empty), 32'd1);

        // three rounds of 40 across the pointer wrap
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 40; i++) step(1'b1, 8'(r * 40 + i), i == 39, 1'b0, 1'b0, 1'b0);
            chk("wrap_count", 32'(count), 32'd40);
            for (int i = 0; i < 40; i++) begin
                chk("wrap_data", 32'(r_data), 32'(8'(r * 40 + i)));
                step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
            end
        end

        // almost flags at their thresholds
        for (int i = 0; i < 55; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("af_55", 32'(almost_full), 32'd0);
        step(1'b1, 8'h37, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("af_56", 32'(almost_full), 32'd1);
        chk("ae_56", 32'(almost_empty), 32'd0);
        for (int i = 0; i < 47; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ae_9", 32'(almost_empty), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ae_8", 32'(almost_empty), 32'd1);

        // asynchronous reset mid-packet clears committed and staged data
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 n_rst = 1'b0;
        #1;
        cq.delete(); sq.delete(); m_ovf = 1'b0; m_udf = 1'b0;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_space", 32'(space), 32'd64);
        chk("mid_rst_r_data", 32'(r_data), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        idle();

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(99) < 60, 8'($urandom), $urandom_range(99) < 10,
                 $urandom_range(99) < 3, $urandom_range(99) < (i % 600 < 300 ? 35 : 65),
                 $urandom_range(99) < 5);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
